ticket_change_dispenser: RTL and testbench
==========================================

# ticket_change_dispenser

Payout-side controller for the ticket vending machine. It accepts one settled transaction: the ticket count and the change owed. It then drives the ticket printer and the coin hopper, issuing one ticket per cycle and then paying the change one coin at a time with a greedy largest-denomination-first rule. The coin hopper uses a valid/ack handshake. The block sits downstream of the fare/payment FSM and is the only path by which tickets and change leave the machine.

## Interface
- No parameters. Denomination set is fixed; see Configuration.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- ticketCount  in  3  tickets to issue; 0..5 legal.
- changeAmount  in  7  change owed in dollars, 0..127.
- coinAck  in  1  hopper has released the presented coin; sampled only while coinValid=1.
- busy  out  1  high in every state except IDLE.
- ticketOut  out  1  one-cycle pulse per ticket issued.
- coinValid  out  1  a coin request is presented.
- coinType  out  2  0=$1, 1=$5, 2=$10, 3=$50; meaningful only while coinValid=1.
- remaining  out  7  change still owed (registered).
- ticketsLeft  out  3  tickets still to issue (registered).
- done  out  1  one-cycle pulse when a transaction completes.
- err  out  1  one-cycle pulse when a start is rejected.

## Operation
- States: IDLE, TICKET, COIN, DONE. Encoding is free.
- IDLE, start=1, ticketCount<=5:
  - Latch ticketsLeft=ticketCount and remaining=changeAmount.
  - Next state is TICKET if ticketCount>0, else COIN if changeAmount>0, else DONE.
- IDLE, start=1, ticketCount>5:
  - err=1 for the next cycle. Nothing is latched. Stay in IDLE.
- IDLE, start=0: hold. coinAck is ignored.
- TICKET:
  - ticketOut=1 every cycle in this state; ticketsLeft decrements each cycle.
  - When ticketsLeft reaches 0, go to COIN if remaining>0, else DONE.
  - N tickets produce exactly N consecutive pulses.
- COIN:
  - coinValid=1 throughout.
  - coinType is the largest enabled denomination <= remaining, derived from the registered remaining.
  - On an edge with coinAck=1, remaining is reduced by that coin's value.
  - If the new remaining is 0, go to DONE; otherwise stay, and the next coinType is presented the following cycle.
  - With coinAck=0, hold coinType and remaining unchanged indefinitely.
- DONE: done=1 for one cycle, then IDLE.
- start while busy=1 is ignored; no err.
- Arithmetic: 7-bit unsigned. Greedy selection guarantees remaining never underflows, and the $1 denomination is always enabled.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- Reset is applied on any edge with reset=1, in any state, and aborts the transaction immediately:
  - no done pulse;
  - the in-flight coinValid drops on the next cycle;
  - an ack arriving on the reset edge is discarded.
- Latency from the start edge:
  - busy=1 on the next cycle;
  - first ticketOut on the next cycle (if ticketCount>0);
  - otherwise first coinValid on the next cycle.
- The last ticketOut cycle is followed directly by the first coinValid cycle (no gap).
- The ack edge that clears remaining to 0 is followed by one done cycle, then busy=0.
- Zero-work transaction (0 tickets, $0 change): start edge, then one DONE cycle with done=1, then IDLE. Total busy time is 1 cycle.
- Transaction time with immediate acks: T + C + 1 cycles, where T is the ticket count and C is the number of coins.
- coinAck held high continuously is legal and releases one coin per cycle.
- A new start is accepted on the first IDLE cycle after DONE.

## Configuration
- COIN50_EN defined:
  - the $50 denomination (coinType=3) is enabled;
  - greedy order is 50, 10, 5, 1.
- COIN50_EN undefined:
  - coinType=3 is never produced;
  - greedy order is 10, 5, 1;
  - all other behaviour is identical.

## Test plan
- ticketCount=3, changeAmount=0, immediate acks:
  - 3 consecutive ticketOut pulses starting the cycle after start;
  - no coinValid;
  - done on cycle 4 after start;
  - busy low on cycle 5.
- ticketCount=2, changeAmount=67, coinAck tied high:
  - with COIN50_EN: coinType sequence 3,2,1,0,0; remaining goes 67→17→7→2→1→0;
  - without COIN50_EN: coinType sequence 2×6, 1, 0, 0 (9 coins);
  - done one cycle after the final coin.
- changeAmount=15, coinAck held low for 5 cycles, then pulsed per coin:
  - coinType stays 2 (the $10 coin) and remaining stays 15 while stalled;
  - then the $10 coin is released, then the $5 coin;
  - done fires after the $5 ack.
- start with ticketCount=6:
  - err pulses one cycle;
  - busy, ticketOut and coinValid all stay 0;
  - remaining is unchanged.
- ticketCount=1, changeAmount=30, reset asserted during the second COIN cycle with coinAck=1:
  - next cycle all outputs are 0 and the state is IDLE;
  - no done pulse.
- start with ticketCount=0, changeAmount=0:
  - busy for exactly 1 cycle, with done=1 in that cycle;
  - a second start pulsed during that busy cycle is ignored.

Source files
------------

// File: rtl/ticket_change_dispenser_if.sv
// Transaction and payout signals of the ticket/change dispenser.
// The controller side uses the slave modport; the fare/payment side uses the master modport.
interface ticket_change_dispenser_if;
  logic       start;
  logic [2:0] ticketCount;
  logic [6:0] changeAmount;
  logic       coinAck;
  logic       busy;
  logic       ticketOut;
  logic       coinValid;
  logic [1:0] coinType;
  logic [6:0] remaining;
  logic [2:0] ticketsLeft;
  logic       done;
  logic       err;

  modport master (
    output start, ticketCount, changeAmount, coinAck,
    input  busy, ticketOut, coinValid, coinType, remaining, ticketsLeft, done, err
  );

  modport slave (
    input  start, ticketCount, changeAmount, coinAck,
    output busy, ticketOut, coinValid, coinType, remaining, ticketsLeft, done, err
  );
endinterface

// File: rtl/ticket_change_dispenser.sv
// Payout controller: issues tickets one per cycle, then pays change greedily via a valid/ack hopper.
// Define COIN50_EN to enable the $50 denomination (coinType=3).
module ticket_change_dispenser (
  input logic                       clk,
  input logic                       reset,
  ticket_change_dispenser_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, TICKET, COIN, DONE} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_remaining;
  logic [6:0] w_remaining_next;
  logic [6:0] w_coin_val;
  logic [6:0] w_after_coin;
  logic [2:0] r_tickets_left;
  logic [2:0] w_tickets_next;
  logic [1:0] w_coin_sel;
  logic       r_busy;
  logic       r_ticket_out;
  logic       r_coin_valid;
  logic       r_done;
  logic       r_err;
  logic       w_err_next;

  // Greedy denomination selection from the registered balance.
  always_comb begin
    w_coin_sel = 2'd0;
    w_coin_val = 7'd1;
`ifdef COIN50_EN
    if (r_remaining >= 7'd50) begin
      w_coin_sel = 2'd3;
      w_coin_val = 7'd50;
    end else
`endif
    if (r_remaining >= 7'd10) begin
      w_coin_sel = 2'd2;
      w_coin_val = 7'd10;
    end else if (r_remaining >= 7'd5) begin
      w_coin_sel = 2'd1;
      w_coin_val = 7'd5;
    end
  end

  assign w_after_coin = r_remaining - w_coin_val;

  always_comb begin
    w_next           = r_state;
    w_remaining_next = r_remaining;
    w_tickets_next   = r_tickets_left;
    w_err_next       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.ticketCount > 3'd5) begin
            w_err_next = 1'b1;
          end else begin
            w_tickets_next   = bus.ticketCount;
            w_remaining_next = bus.changeAmount;
            if (bus.ticketCount != 3'd0)
              w_next = TICKET;
            else if (bus.changeAmount != 7'd0)
              w_next = COIN;
            else
              w_next = DONE;
          end
        end
      end
      TICKET: begin
        w_tickets_next = r_tickets_left - 3'd1;
        if (r_tickets_left <= 3'd1)
          w_next = (r_remaining != 7'd0) ? COIN : DONE;
      end
      COIN: begin
        if (bus.coinAck) begin
          w_remaining_next = w_after_coin;
          if (w_after_coin == 7'd0)
            w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_remaining    <= '0;
      r_tickets_left <= '0;
      r_busy         <= 1'b0;
      r_ticket_out   <= 1'b0;
      r_coin_valid   <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_remaining    <= w_remaining_next;
      r_tickets_left <= w_tickets_next;
      r_busy         <= (w_next != IDLE);
      r_ticket_out   <= (w_next == TICKET);
      r_coin_valid   <= (w_next == COIN);
      r_done         <= (w_next == DONE);
      r_err          <= w_err_next;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.ticketOut   = r_ticket_out;
  assign bus.coinValid   = r_coin_valid;
  assign bus.coinType    = r_coin_valid ? w_coin_sel : '0;
  assign bus.remaining   = r_remaining;
  assign bus.ticketsLeft = r_tickets_left;
  assign bus.done        = r_done;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_ticket_change_dispenser.sv
// Directed testbench for ticket_change_dispenser; honours COIN50_EN for the expected coin sequences.
module tb_ticket_change_dispenser;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;
  int   exp_t[$];
  int   exp_r[$];

  ticket_change_dispenser_if bus ();

  ticket_change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input int tc, input int ch);
    bus.start        = 1'b1;
    bus.ticketCount  = tc[2:0];
    bus.changeAmount = ch[6:0];
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    n_total          = 0;
    n_pass           = 0;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.ticketCount  = '0;
    bus.changeAmount = '0;
    bus.coinAck      = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", bus.busy, 0);
    check("rst_ticket", bus.ticketOut, 0);
    check("rst_coinvalid", bus.coinValid, 0);
    check("rst_cointype", bus.coinType, 0);
    check("rst_remaining", bus.remaining, 0);
    check("rst_tleft", bus.ticketsLeft, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);

    // 3 tickets, no change
    bus.coinAck = 1'b1;
    start_txn(3, 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_ticket", bus.ticketOut, 1);
      check("t3_busy", bus.busy, 1);
      check("t3_coinvalid", bus.coinValid, 0);
      check("t3_tleft", bus.ticketsLeft, 3 - i);
      tick();
    end
    check("t3_done", bus.done, 1);
    check("t3_ticket_end", bus.ticketOut, 0);
    check("t3_busy_done", bus.busy, 1);
    tick();
    check("t3_busy_low", bus.busy, 0);
    check("t3_done_low", bus.done, 0);

    // 2 tickets, $67 change, ack tied high
`ifdef COIN50_EN
    exp_t = '{3, 2, 1, 0, 0};
    exp_r = '{67, 17, 7, 2, 1};
`else
    exp_t = '{2, 2, 2, 2, 2, 2, 1, 0, 0};
    exp_r = '{67, 57, 47, 37, 27, 17, 7, 2, 1};
`endif
    start_txn(2, 67);
    for (int i = 0; i < 2; i++) begin
      check("c67_ticket", bus.ticketOut, 1);
      check("c67_novalid", bus.coinValid, 0);
      tick();
    end
    foreach (exp_t[i]) begin
      check("c67_valid", bus.coinValid, 1);
      check("c67_ticket_off", bus.ticketOut, 0);
      check("c67_type", bus.coinType, exp_t[i]);
      check("c67_rem", bus.remaining, exp_r[i]);
      tick();
    end
    check("c67_done", bus.done, 1);
    check("c67_rem0", bus.remaining, 0);
    check("c67_valid_off", bus.coinValid, 0);
    tick();
    check("c67_idle", bus.busy, 0);
    bus.coinAck = 1'b0;

    // $15 with stalled hopper
    start_txn(0, 15);
    for (int i = 0; i < 5; i++) begin
      check("s15_valid", bus.coinValid, 1);
      check("s15_type", bus.coinType, 2);
      check("s15_rem", bus.remaining, 15);
      tick();
    end
    bus.coinAck = 1'b1;
    tick();
    bus.coinAck = 1'b0;
    check("s15_type5", bus.coinType, 1);
    check("s15_rem5", bus.remaining, 5);
    tick();
    check("s15_hold5", bus.remaining, 5);
    check("s15_nodone", bus.done, 0);
    bus.coinAck = 1'b1;
    tick();
    bus.coinAck = 1'b0;
    check("s15_done", bus.done, 1);
    check("s15_rem0", bus.remaining, 0);
    tick();
    check("s15_idle", bus.busy, 0);

    // Rejected start
    start_txn(6, 33);
    check("e6_err", bus.err, 1);
    check("e6_busy", bus.busy, 0);
    check("e6_ticket", bus.ticketOut, 0);
    check("e6_valid", bus.coinValid, 0);
    check("e6_rem", bus.remaining, 0);
    tick();
    check("e6_err_pulse", bus.err, 0);
    check("e6_busy2", bus.busy, 0);

    // Reset during second coin cycle with ack high
    bus.coinAck = 1'b1;
    start_txn(1, 30);
    check("r30_ticket", bus.ticketOut, 1);
    tick();
    check("r30_type", bus.coinType, 2);
    check("r30_rem", bus.remaining, 30);
    tick();
    check("r30_rem2", bus.remaining, 20);
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    bus.coinAck = 1'b0;
    check("r30_busy", bus.busy, 0);
    check("r30_valid", bus.coinValid, 0);
    check("r30_type0", bus.coinType, 0);
    check("r30_rem0", bus.remaining, 0);
    check("r30_done", bus.done, 0);
    tick();
    check("r30_nodone", bus.done, 0);
    check("r30_idle", bus.busy, 0);

    // Zero-work transaction with a start during the busy cycle
    start_txn(0, 0);
    check("z_busy", bus.busy, 1);
    check("z_done", bus.done, 1);
    bus.start        = 1'b1;
    bus.ticketCount  = 3'd2;
    bus.changeAmount = 7'd5;
    tick();
    bus.start = 1'b0;
    check("z_idle", bus.busy, 0);
    check("z_ignored_ticket", bus.ticketOut, 0);
    check("z_done_off", bus.done, 0);
    check("z_tleft", bus.ticketsLeft, 0);

    // Start accepted on first IDLE cycle, ticket then coin with no gap
    bus.coinAck = 1'b1;
    start_txn(1, 1);
    check("n_ticket", bus.ticketOut, 1);
    tick();
    check("n_valid", bus.coinValid, 1);
    check("n_type", bus.coinType, 0);
    check("n_rem", bus.remaining, 1);
    tick();
    check("n_done", bus.done, 1);
    tick();
    check("n_idle", bus.busy, 0);
    bus.coinAck = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
